// File: rtl/axi_rd_arbiter_if.sv
// Read-channel bundle shared by the two upstream requesters and the
// downstream AXI port: address handshake plus read-data handshake.
interface axi_rd_arbiter_if;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    // Side that issues read requests and consumes data.
    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rlast, rvalid
    );

    // Side that accepts read requests and returns data.
    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-into-one AXI read arbiter: instruction and data requesters share a
// single downstream read port, one burst outstanding at a time, with
// round-robin arbitration on ties. Beats are routed by the registered grant.
module axi_rd_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic               clk,
    input  logic               rst,
    axi_rd_arbiter_if.slave    i_bus,
    axi_rd_arbiter_if.slave    d_bus,
    axi_rd_arbiter_if.master   m_bus,
    output logic [3:0]         m_arid,
    output logic [2:0]         m_arsize,
    output logic [1:0]         m_arburst,
    input  logic [3:0]         m_rid
);

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        grant_d_r;     // 1: data side owns the current burst
    logic        grant_d_s;
    logic        last_d_r;      // 1: data side owned the previous burst
    logic        start_s;       // IDLE -> ADDR transition this cycle
    logic        done_s;        // last beat handed over this cycle
    logic [31:0] araddr_r;
    logic [3:0]  arlen_r;
    logic [3:0]  arid_r;

    logic        m_arvalid_s;
    logic        m_rready_s;
    logic        i_arready_s;
    logic        d_arready_s;
    logic [31:0] i_rdata_s;
    logic [31:0] d_rdata_s;
    logic        i_rlast_s;
    logic        d_rlast_s;
    logic        i_rvalid_s;
    logic        d_rvalid_s;

    // Routing ignores the downstream ID; it is consumed here only.
    logic        unused_rid_s;
    assign unused_rid_s = ^m_rid;

    // Next-state, grant selection and all handshake/data routing.
    always_comb begin
        state_s     = state_r;
        grant_d_s   = grant_d_r;
        start_s     = 1'b0;
        done_s      = 1'b0;
        m_arvalid_s = 1'b0;
        m_rready_s  = 1'b0;
        i_arready_s = 1'b0;
        d_arready_s = 1'b0;
        i_rdata_s   = 32'h0000_0000;
        d_rdata_s   = 32'h0000_0000;
        i_rlast_s   = 1'b0;
        d_rlast_s   = 1'b0;
        i_rvalid_s  = 1'b0;
        d_rvalid_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_bus.arvalid || d_bus.arvalid) begin
                    start_s = 1'b1;
                    state_s = ST_ADDR;
                    if (i_bus.arvalid && d_bus.arvalid) begin
                        // Tie: the side that did not win last time goes now.
                        grant_d_s = ~last_d_r;
                    end else begin
                        grant_d_s = d_bus.arvalid;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                m_arvalid_s = 1'b1;
                if (grant_d_r) begin
                    d_arready_s = m_bus.arready;
                end else begin
                    i_arready_s = m_bus.arready;
                end
                if (m_bus.arready) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (grant_d_r) begin
                    m_rready_s = d_bus.rready;
                    d_rdata_s  = m_bus.rdata;
                    d_rlast_s  = m_bus.rlast;
                    d_rvalid_s = m_bus.rvalid;
                end else begin
                    m_rready_s = i_bus.rready;
                    i_rdata_s  = m_bus.rdata;
                    i_rlast_s  = m_bus.rlast;
                    i_rvalid_s = m_bus.rvalid;
                end
                if (m_bus.rvalid && m_rready_s && m_bus.rlast) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, fairness history and latched downstream address fields.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            grant_d_r <= 1'b0;
            last_d_r  <= 1'b0;
            araddr_r  <= 32'h0000_0000;
            arlen_r   <= 4'd0;
            arid_r    <= INST_ID;
        end else begin
            if (start_s) begin
                grant_d_r <= grant_d_s;
                araddr_r  <= grant_d_s ? d_bus.araddr : i_bus.araddr;
                arlen_r   <= grant_d_s ? d_bus.arlen  : i_bus.arlen;
                arid_r    <= grant_d_s ? DATA_ID      : INST_ID;
            end else begin
                grant_d_r <= grant_d_r;
                araddr_r  <= araddr_r;
                arlen_r   <= arlen_r;
                arid_r    <= arid_r;
            end
            if (done_s) begin
                last_d_r <= grant_d_r;
            end else begin
                last_d_r <= last_d_r;
            end
        end
    end

    assign m_bus.araddr  = araddr_r;
    assign m_bus.arlen   = arlen_r;
    assign m_arid        = arid_r;
    assign m_arsize      = 3'b010;
    assign m_arburst     = 2'b01;
    assign m_bus.arvalid = m_arvalid_s;
    assign m_bus.rready  = m_rready_s;

    assign i_bus.arready = i_arready_s;
    assign i_bus.rdata   = i_rdata_s;
    assign i_bus.rlast   = i_rlast_s;
    assign i_bus.rvalid  = i_rvalid_s;

    assign d_bus.arready = d_arready_s;
    assign d_bus.rdata   = d_rdata_s;
    assign d_bus.rlast   = d_rlast_s;
    assign d_bus.rvalid  = d_rvalid_s;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: arbitration order, address hold,
// beat routing under back-pressure and mid-burst reset.
module tb_axi_rd_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] m_arid;
    logic [2:0] m_arsize;
    logic [1:0] m_arburst;
    logic [3:0] m_rid;

    int checks;
    int failures;

    axi_rd_arbiter_if ibus ();
    axi_rd_arbiter_if dbus ();
    axi_rd_arbiter_if mbus ();

    axi_rd_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_bus     (ibus),
        .d_bus     (dbus),
        .m_bus     (mbus),
        .m_arid    (m_arid),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_rid     (m_rid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Deliver nbeats downstream beats (rready assumed high) and check routing.
    task automatic serve(input bit exp_d, input int nbeats, input logic [31:0] base);
        for (int b = 0; b < nbeats; b++) begin
            mbus.rvalid = 1'b1;
            mbus.rdata  = base + 32'(b);
            mbus.rlast  = (b == nbeats - 1);
            #1;
            chk("m_rready_beat", {31'd0, mbus.rready}, 32'd1);
            if (exp_d) begin
                chk("d_rvalid_beat", {31'd0, dbus.rvalid}, 32'd1);
                chk("d_rdata_beat",  dbus.rdata, base + 32'(b));
                chk("d_rlast_beat",  {31'd0, dbus.rlast}, (b == nbeats - 1) ? 32'd1 : 32'd0);
                chk("i_rvalid_idle", {31'd0, ibus.rvalid}, 32'd0);
                chk("i_rdata_idle",  ibus.rdata, 32'd0);
            end else begin
                chk("i_rvalid_beat", {31'd0, ibus.rvalid}, 32'd1);
                chk("i_rdata_beat",  ibus.rdata, base + 32'(b));
                chk("i_rlast_beat",  {31'd0, ibus.rlast}, (b == nbeats - 1) ? 32'd1 : 32'd0);
                chk("d_rvalid_idle", {31'd0, dbus.rvalid}, 32'd0);
                chk("d_rdata_idle",  dbus.rdata, 32'd0);
            end
            cyc();
        end
        mbus.rvalid = 1'b0;
        mbus.rlast  = 1'b0;
        #1;
        chk("post_i_rvalid", {31'd0, ibus.rvalid}, 32'd0);
        chk("post_d_rvalid", {31'd0, dbus.rvalid}, 32'd0);
        chk("post_m_rready", {31'd0, mbus.rready}, 32'd0);
    endtask

    initial begin
        int b;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        m_rid = 4'h0;
        ibus.araddr = 32'h0; ibus.arlen = 4'd0; ibus.arvalid = 1'b0; ibus.rready = 1'b0;
        dbus.araddr = 32'h0; dbus.arlen = 4'd0; dbus.arvalid = 1'b0; dbus.rready = 1'b0;
        mbus.arready = 1'b0; mbus.rdata = 32'h0; mbus.rlast = 1'b0; mbus.rvalid = 1'b0;

        // ---- reset values
        cyc();
        cyc();
        chk("rst_m_arvalid", {31'd0, mbus.arvalid}, 32'd0);
        chk("rst_m_rready",  {31'd0, mbus.rready}, 32'd0);
        chk("rst_m_araddr",  mbus.araddr, 32'd0);
        chk("rst_m_arlen",   {28'd0, mbus.arlen}, 32'd0);
        chk("rst_m_arid",    {28'd0, m_arid}, 32'd0);
        chk("rst_arsize",    {29'd0, m_arsize}, 32'd2);
        chk("rst_arburst",   {30'd0, m_arburst}, 32'd1);
        chk("rst_i_arready", {31'd0, ibus.arready}, 32'd0);
        chk("rst_d_arready", {31'd0, dbus.arready}, 32'd0);
        chk("rst_i_rvalid",  {31'd0, ibus.rvalid}, 32'd0);
        chk("rst_d_rdata",   dbus.rdata, 32'd0);
        rst = 1'b0;
        cyc();

        // ---- lone instruction burst, 8 beats
        ibus.araddr = 32'hBFC0_0000; ibus.arlen = 4'd7; ibus.arvalid = 1'b1;
        ibus.rready = 1'b1; mbus.arready = 1'b1;
        #1;
        chk("t1_idle_arvalid", {31'd0, mbus.arvalid}, 32'd0);
        cyc();
        chk("t1_arvalid",  {31'd0, mbus.arvalid}, 32'd1);
        chk("t1_arid",     {28'd0, m_arid}, 32'd0);
        chk("t1_arlen",    {28'd0, mbus.arlen}, 32'd7);
        chk("t1_araddr",   mbus.araddr, 32'hBFC0_0000);
        chk("t1_i_arready", {31'd0, ibus.arready}, 32'd1);
        chk("t1_d_arready", {31'd0, dbus.arready}, 32'd0);
        ibus.arvalid = 1'b0;
        cyc();
        chk("t1_arvalid_drop", {31'd0, mbus.arvalid}, 32'd0);
        serve(1'b0, 8, 32'h0000_1000);
        chk("t1_idle_after", {31'd0, mbus.arvalid}, 32'd0);

        // ---- simultaneous requests after reset: data wins, inst after bubble
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ibus.araddr = 32'h0000_0100; ibus.arlen = 4'd1; ibus.arvalid = 1'b1;
        dbus.araddr = 32'h0000_0200; dbus.arlen = 4'd1; dbus.arvalid = 1'b1;
        dbus.rready = 1'b1;
        cyc();
        chk("t2_arid_d",     {28'd0, m_arid}, 32'd1);
        chk("t2_araddr_d",   mbus.araddr, 32'h0000_0200);
        chk("t2_d_arready",  {31'd0, dbus.arready}, 32'd1);
        chk("t2_i_arready",  {31'd0, ibus.arready}, 32'd0);
        dbus.arvalid = 1'b0;
        cyc();
        serve(1'b1, 2, 32'h0000_2000);
        chk("t2_bubble_arvalid", {31'd0, mbus.arvalid}, 32'd0);
        chk("t2_bubble_arready", {31'd0, ibus.arready}, 32'd0);
        cyc();
        chk("t2_arid_i",   {28'd0, m_arid}, 32'd0);
        chk("t2_araddr_i", mbus.araddr, 32'h0000_0100);
        chk("t2_arvalid_i", {31'd0, mbus.arvalid}, 32'd1);
        ibus.arvalid = 1'b0;
        cyc();
        serve(1'b0, 2, 32'h0000_3000);

        // ---- continuous single-beat requests from both: d,i,d,i,d,i
        ibus.araddr = 32'h0000_0300; ibus.arlen = 4'd0; ibus.arvalid = 1'b1;
        dbus.araddr = 32'h0000_0400; dbus.arlen = 4'd0; dbus.arvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t3_arid",   {28'd0, m_arid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_araddr", mbus.araddr, (k % 2 == 0) ? 32'h0000_0400 : 32'h0000_0300);
            cyc();
            serve((k % 2 == 0), 1, 32'h0000_4000 + 32'(k * 16));
        end
        ibus.arvalid = 1'b0;
        dbus.arvalid = 1'b0;

        // ---- address held while m_arready low for 5 cycles
        dbus.araddr = 32'h0000_0500; dbus.arlen = 4'd0; dbus.arvalid = 1'b1;
        mbus.arready = 1'b0;
        cyc();
        for (int w = 0; w < 5; w++) begin
            chk("t4_wait_arvalid", {31'd0, mbus.arvalid}, 32'd1);
            chk("t4_wait_araddr",  mbus.araddr, 32'h0000_0500);
            chk("t4_wait_arready", {31'd0, dbus.arready}, 32'd0);
            cyc();
        end
        mbus.arready = 1'b1;
        #1;
        chk("t4_acc_arvalid", {31'd0, mbus.arvalid}, 32'd1);
        chk("t4_acc_araddr",  mbus.araddr, 32'h0000_0500);
        chk("t4_acc_arready", {31'd0, dbus.arready}, 32'd1);
        dbus.arvalid = 1'b0;
        cyc();
        chk("t4_post_arready", {31'd0, dbus.arready}, 32'd0);
        chk("t4_post_arvalid", {31'd0, mbus.arvalid}, 32'd0);
        serve(1'b1, 1, 32'h0000_5000);

        // ---- data rready toggling during a 4-beat burst
        dbus.araddr = 32'h0000_0600; dbus.arlen = 4'd3; dbus.arvalid = 1'b1;
        cyc();
        dbus.arvalid = 1'b0;
        cyc();
        b = 0;
        for (int c = 0; c < 8; c++) begin
            dbus.rready = (c % 2 == 0);
            mbus.rvalid = 1'b1;
            mbus.rdata  = 32'h0000_6000 + 32'(b);
            mbus.rlast  = (b == 3);
            #1;
            chk("t5_m_rready", {31'd0, mbus.rready}, {31'd0, dbus.rready});
            chk("t5_d_rvalid", {31'd0, dbus.rvalid}, 32'd1);
            chk("t5_d_rdata",  dbus.rdata, 32'h0000_6000 + 32'(b));
            chk("t5_i_rvalid", {31'd0, ibus.rvalid}, 32'd0);
            if (dbus.rready) b++;
            cyc();
            if (b == 4) break;
        end
        mbus.rvalid = 1'b0;
        mbus.rlast  = 1'b0;
        dbus.rready = 1'b1;
        #1;
        chk("t5_end_m_rready", {31'd0, mbus.rready}, 32'd0);
        chk("t5_end_d_rvalid", {31'd0, dbus.rvalid}, 32'd0);

        // ---- reset on beat 3 of an 8-beat burst
        ibus.araddr = 32'h0000_0700; ibus.arlen = 4'd7; ibus.arvalid = 1'b1;
        cyc();
        ibus.arvalid = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            mbus.rvalid = 1'b1; mbus.rdata = 32'h0000_7000 + 32'(k); mbus.rlast = 1'b0;
            cyc();
        end
        mbus.rdata = 32'h0000_7002;
        rst = 1'b1;
        #1;
        chk("t6_beat3_rvalid", {31'd0, ibus.rvalid}, 32'd1);
        cyc();
        chk("t6_rst_i_rvalid", {31'd0, ibus.rvalid}, 32'd0);
        chk("t6_rst_i_rdata",  ibus.rdata, 32'd0);
        chk("t6_rst_m_rready", {31'd0, mbus.rready}, 32'd0);
        chk("t6_rst_arvalid",  {31'd0, mbus.arvalid}, 32'd0);
        chk("t6_rst_araddr",   mbus.araddr, 32'd0);
        chk("t6_rst_arlen",    {28'd0, mbus.arlen}, 32'd0);
        chk("t6_rst_arid",     {28'd0, m_arid}, 32'd0);
        rst = 1'b0;
        mbus.rvalid = 1'b0;
        ibus.araddr = 32'h0000_0800; ibus.arlen = 4'd0; ibus.arvalid = 1'b1;
        dbus.araddr = 32'h0000_0900; dbus.arlen = 4'd0; dbus.arvalid = 1'b1;
        cyc();
        chk("t6_regrant_arid",   {28'd0, m_arid}, 32'd1);
        chk("t6_regrant_araddr", mbus.araddr, 32'h0000_0900);
        chk("t6_regrant_valid",  {31'd0, mbus.arvalid}, 32'd1);
        dbus.arvalid = 1'b0;
        ibus.arvalid = 1'b0;
        cyc();
        serve(1'b1, 1, 32'h0000_9000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter INST_ID, default 4'd0: ARID driven for instruction-side bursts.
REQ-002 Parameter DATA_ID, default 4'd1: ARID driven for data-side bursts.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high (rst == `RST_ENABLE).
REQ-005 i_araddr / i_arlen / i_arvalid  in  32/4/1  instruction-side read request; arlen is beats-1.
REQ-006 i_arready  out  1  instruction-side address accepted.
REQ-007 i_rdata / i_rlast / i_rvalid  out  32/1/1  instruction-side read data beat.
REQ-008 i_rready  in  1  instruction-side data ready.
REQ-009 d_araddr / d_arlen / d_arvalid / d_arready / d_rdata / d_rlast / d_rvalid / d_rready: data-side equivalents of REQ-005..008, same widths and directions.
REQ-010 m_arid / m_araddr / m_arlen  out  4/32/4  downstream AXI read address.
REQ-011 m_arsize / m_arburst  out  3/2  constant 3'b010 and 2'b01 (INCR).
REQ-012 m_arvalid  out  1 / m_arready  in  1  downstream address handshake.
REQ-013 m_rid / m_rdata / m_rlast / m_rvalid  in  4/32/1/1  downstream read data.
REQ-014 m_rready  out  1  downstream data ready.

Function
REQ-015 One outstanding burst at a time; states IDLE, ADDR, DATA.
REQ-016 IDLE: if any of i_arvalid/d_arvalid is high, register the grant and go to ADDR next cycle. Otherwise stay in IDLE.
REQ-017 Arbitration is round-robin: with both requests high, grant the side not granted last. After reset, the data side wins the first tie.
REQ-018 A lone requester is granted regardless of last grant.
REQ-019 ADDR: m_arvalid=1. m_araddr/m_arlen/m_arid are muxed from the registered grant.
REQ-020 ADDR: the granted side's arready is m_arready. The other side's arready is 0.
REQ-021 ADDR: on m_arvalid && m_arready, go to DATA next cycle.
REQ-022 m_arvalid is held high, with address stable, until accepted; no timeout.
REQ-023 DATA: granted side's rdata/rlast/rvalid equal m_rdata/m_rlast/m_rvalid; m_rready equals the granted side's rready.
REQ-024 DATA: the non-granted side's rvalid/rlast are 0 and its rdata is 32'h0.
REQ-025 DATA: on m_rvalid && m_rready && m_rlast, go to IDLE and update last-grant.
REQ-026 The earliest re-grant is the cycle after the last beat, so there is one idle bubble between bursts.
REQ-027 m_rid is not checked; beats are routed by the registered grant only.
REQ-028 A request dropped while not granted is ignored. A granted requester must hold arvalid until arready (AXI rule).
REQ-029 Outside DATA: m_rready=0, and both rvalid outputs are 0.
REQ-030 Outside ADDR: m_arvalid=0, and both arready outputs are 0.
REQ-031 Request-to-m_arvalid latency is one cycle from IDLE.

Reset
REQ-032 On rst: state=IDLE, last-grant=inst (so data wins the first tie), m_arvalid=0, m_rready=0.
REQ-033 On rst: i/d_arready=0, i/d_rvalid=0, i/d_rlast=0, i/d_rdata=0.
REQ-034 On rst: m_araddr=0, m_arlen=0, m_arid=INST_ID.
REQ-035 Reset asserted mid-ADDR or mid-DATA aborts to IDLE the next cycle; remaining downstream beats are not forwarded.

Verification
REQ-036 Lone inst request (addr 0xBFC00000, arlen 7), arready at once, 8 beats, rready=1 -> m_arid=0, m_arlen=7, m_arvalid high exactly 1 cycle, i_rvalid for 8 beats, last beat with i_rlast, back to IDLE.
REQ-037 Both request in the same cycle after reset -> data granted first (m_arid=1). Inst granted after data's rlast plus one bubble cycle.
REQ-038 Both requesters continuously requesting single beats (arlen 0) for 6 bursts -> grants alternate d,i,d,i,d,i.
REQ-039 m_arready held low 5 cycles -> m_arvalid and m_araddr are stable for 6 cycles, and the granted arready pulses only in the accept cycle.
REQ-040 d_rready toggles during a 4-beat data burst -> m_rready follows d_rready, no beat is lost or duplicated, and i_rvalid stays 0.
REQ-041 rst asserted on beat 3 of an 8-beat burst -> next cycle: IDLE, all outputs at reset values, and the following request is arbitrated normally.
